// File: rtl/microuaz_pkg.sv
// Shared MicroUAZ8 definitions: loader state encoding, frame marker, default widths
// and instruction field positions used by both the loader and Control_unit.
package microuaz_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 9;

    localparam logic [7:0] START_BYTE = 8'hA5;

    // Instruction word layout: opcode[8:6], field A[5:3], field B[2:0]
    localparam int OPC_MSB = 8;
    localparam int OPC_LSB = 6;
    localparam int FA_MSB  = 5;
    localparam int FA_LSB  = 3;
    localparam int FB_MSB  = 2;
    localparam int FB_LSB  = 0;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_LEN,
        LD_LO,
        LD_HI,
        LD_WR,
        LD_RUN,
        LD_ERR,
        LD_CHK
    } ld_state_e;

    // A count byte of zero means a full 256-word program.
    function automatic logic [8:0] count_to_words(input logic [7:0] n);
        return {(n == 8'd0), n};
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Loader bus: byte stream in, instruction fetch port, CPU hold and load status.
interface program_loader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 9
);
    logic [7:0]        i_Byte;
    logic              i_Byte_Valid;
    logic              o_Byte_Ready;
    logic [ADDR_W-1:0] i_Addres_Instr_Bus;
    logic [DATA_W-1:0] o_Instruction;
    logic              o_Cpu_Hold;
    logic              o_Load_Done;
    logic              o_Load_Err;

    modport master (
        output i_Byte, i_Byte_Valid, i_Addres_Instr_Bus,
        input  o_Byte_Ready, o_Instruction, o_Cpu_Hold, o_Load_Done, o_Load_Err
    );

    modport slave (
        input  i_Byte, i_Byte_Valid, i_Addres_Instr_Bus,
        output o_Byte_Ready, o_Instruction, o_Cpu_Hold, o_Load_Done, o_Load_Err
    );
endinterface

// File: rtl/program_loader_instr_ram.sv
// Instruction store: one synchronous write port, one registered read port.
// The array itself is never reset; only the read register clears.
module instr_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 9
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data_p1
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge Clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Read stage: same-address write in this cycle still returns the old word
    always_ff @(posedge Clk) begin
        if (!Rst) rd_data_p1 <= '0;
        else      rd_data_p1 <= mem[rd_addr];
    end

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream program loader for MicroUAZ8; holds the CPU until a load completes.
// Optional checksum byte after the last pair when PROGRAM_LOADER_CHECKSUM_EN is defined.
module program_loader #(
    parameter int         ADDR_W     = microuaz_pkg::DEF_ADDR_W,
    parameter int         DATA_W     = microuaz_pkg::DEF_DATA_W,
    parameter logic [7:0] START_BYTE = microuaz_pkg::START_BYTE
) (
    input logic             Clk,
    input logic             Rst,
    program_loader_if.slave bus
);
    import microuaz_pkg::*;

    ld_state_e         state_q, state_d;
    logic [ADDR_W-1:0] wr_addr;
    logic [8:0]        words_left;
    logic [7:0]        lo_q;
    logic              hi_q;
    logic              done_q;
    logic              byte_ready;
    logic              xfer;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]        chk_q;
`endif

    assign byte_ready = (state_q != LD_WR);
    assign xfer       = bus.i_Byte_Valid && byte_ready;
    assign wr_en      = (state_q == LD_WR);
    assign wr_data    = {hi_q, lo_q};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LD_IDLE: if (xfer && bus.i_Byte == START_BYTE) state_d = LD_LEN;
            LD_LEN:  if (xfer) state_d = LD_LO;
            LD_LO:   if (xfer) state_d = LD_HI;
            LD_HI:   if (xfer) state_d = (bus.i_Byte[7:1] != 7'd0) ? LD_ERR : LD_WR;
            LD_WR: begin
                if (words_left == 9'd1)
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    state_d = LD_CHK;
`else
                    state_d = LD_RUN;
`endif
                else
                    state_d = LD_LO;
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            LD_CHK:  if (xfer) state_d = (bus.i_Byte == chk_q) ? LD_RUN : LD_ERR;
`endif
            LD_RUN, LD_ERR: if (xfer && bus.i_Byte == START_BYTE) state_d = LD_LEN;
            default: state_d = LD_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q    <= LD_IDLE;
            wr_addr    <= '0;
            words_left <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            // Done is registered so it lines up with the first RUN cycle
            done_q  <= (state_d == LD_RUN) && (state_q != LD_RUN);
            if (state_q == LD_LEN && xfer) begin
                words_left <= count_to_words(bus.i_Byte);
                wr_addr    <= '0;
            end
            if (wr_en) begin
                wr_addr    <= wr_addr + ADDR_W'(1);
                words_left <= words_left - 9'd1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (state_q == LD_LO && xfer) lo_q <= bus.i_Byte;
        if (state_q == LD_HI && xfer) hi_q <= bus.i_Byte[0];
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        if (state_q == LD_LEN && xfer)
            chk_q <= 8'h00;
        else if ((state_q == LD_LO || state_q == LD_HI) && xfer)
            chk_q <= chk_q ^ bus.i_Byte;
`endif
    end

    instr_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
        .Clk        (Clk),
        .Rst        (Rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr    (bus.i_Addres_Instr_Bus),
        .rd_data_p1 (bus.o_Instruction)
    );

    assign bus.o_Byte_Ready = byte_ready;
    assign bus.o_Cpu_Hold   = (state_q != LD_RUN);
    assign bus.o_Load_Err   = (state_q == LD_ERR);
    assign bus.o_Load_Done  = done_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: frames, fetches, error recovery, full-depth load, reset mid-load.
module tb_program_loader;
    import microuaz_pkg::*;

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    always #5 Clk = ~Clk;

    program_loader_if #(.ADDR_W(8), .DATA_W(9)) bus ();

    program_loader dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int rdy_lo_cnt = 0;
    int done_hold_bad = 0;

    always @(negedge Clk) begin
        if (bus.o_Load_Done) done_cnt++;
        if (!bus.o_Byte_Ready) rdy_lo_cnt++;
        if (bus.o_Load_Done && bus.o_Cpu_Hold) done_hold_bad++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge Clk);
        bus.i_Byte       = b;
        bus.i_Byte_Valid = 1'b1;
        while (!bus.o_Byte_Ready && n < 8) begin
            @(negedge Clk);
            n++;
        end
        if (!bus.o_Byte_Ready) check("byte_ready_wait", 32'(bus.o_Byte_Ready), 32'd1);
        @(posedge Clk);
        #1;
        bus.i_Byte_Valid = 1'b0;
    endtask

    task automatic send_raw(input logic [7:0] q[$]);
        foreach (q[i]) send_byte(q[i]);
    endtask

    // Full frame starting with START_BYTE and the count; adds the checksum when enabled
    task automatic send_prog(input logic [7:0] q[$]);
        foreach (q[i]) send_byte(q[i]);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        begin
            logic [7:0] sum;
            sum = 8'h00;
            for (int i = 2; i < q.size(); i++) sum ^= q[i];
            send_byte(sum);
        end
`endif
    endtask

    task automatic fetch_chk(input string tag, input logic [7:0] addr, input logic [8:0] exp);
        @(negedge Clk);
        bus.i_Addres_Instr_Bus = addr;
        @(negedge Clk);
        check(tag, 32'(bus.o_Instruction), 32'(exp));
    endtask

    initial begin
        logic [7:0] q[$];
        int d0;
        int r0;

        bus.i_Byte             = 8'h00;
        bus.i_Byte_Valid       = 1'b0;
        bus.i_Addres_Instr_Bus = 8'h00;

        repeat (3) @(negedge Clk);
        check("rst_instr", 32'(bus.o_Instruction), 32'h0);
        check("rst_hold",  32'(bus.o_Cpu_Hold),    32'd1);
        check("rst_ready", 32'(bus.o_Byte_Ready),  32'd1);
        check("rst_done",  32'(bus.o_Load_Done),   32'd0);
        check("rst_err",   32'(bus.o_Load_Err),    32'd0);
        check("rst_state", 32'(dut.state_q),       32'(LD_IDLE));
        check("rst_addr",  32'(dut.wr_addr),       32'd0);

        Rst = 1'b1;
        repeat (10) @(negedge Clk);
        check("idle_hold", 32'(bus.o_Cpu_Hold), 32'd1);
        check("idle_err",  32'(bus.o_Load_Err), 32'd0);
        check("idle_done_cnt", 32'(done_cnt),   32'd0);

        // Two-word program
        d0 = done_cnt;
        q = {8'hA5, 8'h02, 8'h0C, 8'h00, 8'hD1, 8'h00};
        send_prog(q);
        repeat (3) @(negedge Clk);
        check("t1_done_once", 32'(done_cnt - d0), 32'd1);
        check("t1_hold",      32'(bus.o_Cpu_Hold), 32'd0);
        check("t1_err",       32'(bus.o_Load_Err), 32'd0);
        fetch_chk("t1_rd0", 8'd0, 9'h00C);
        fetch_chk("t1_rd1", 8'd1, 9'h0D1);

        // Single jump word; ready drops for exactly the WR cycle
        r0 = rdy_lo_cnt;
        q = {8'hA5, 8'h01, 8'h54, 8'h01};
        send_raw(q);
        repeat (4) @(negedge Clk);
        check("t2_ready_low_cycles", 32'(rdy_lo_cnt - r0), 32'd1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send_byte(8'h55);
`endif
        repeat (2) @(negedge Clk);
        check("t2_hold", 32'(bus.o_Cpu_Hold), 32'd0);
        fetch_chk("t2_rd0", 8'd0, 9'h154);

        // Illegal HI byte during a reload, then recovery
        check("t3_hold_run", 32'(bus.o_Cpu_Hold), 32'd0);
        send_byte(8'hA5);
        check("t3_hold_reload", 32'(bus.o_Cpu_Hold), 32'd1);
        q = {8'h01, 8'hFF, 8'h02};
        send_raw(q);
        check("t3_err",      32'(bus.o_Load_Err), 32'd1);
        check("t3_err_hold", 32'(bus.o_Cpu_Hold), 32'd1);
        send_byte(8'h01);
        check("t3_err_discard", 32'(bus.o_Load_Err), 32'd1);
        d0 = done_cnt;
        send_byte(8'hA5);
        check("t3_err_clear", 32'(bus.o_Load_Err), 32'd0);
        q = {8'h01, 8'h00, 8'h00};
        send_raw(q);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send_byte(8'h00);
`endif
        repeat (3) @(negedge Clk);
        check("t3_rerun_hold", 32'(bus.o_Cpu_Hold),   32'd0);
        check("t3_rerun_err",  32'(bus.o_Load_Err),   32'd0);
        check("t3_rerun_done", 32'(done_cnt - d0),    32'd1);
        fetch_chk("t3_rd0", 8'd0, 9'h000);

        // Full 256-word program, word = address
        q = {8'hA5, 8'h00};
        for (int i = 0; i < 256; i++) begin
            q.push_back(i[7:0]);
            q.push_back(8'h00);
        end
        send_prog(q);
        repeat (3) @(negedge Clk);
        check("t4_hold", 32'(bus.o_Cpu_Hold), 32'd0);
        check("t4_wrap", 32'(dut.wr_addr),    32'd0);
        for (int i = 0; i < 256; i++)
            fetch_chk($sformatf("t4_rd%0d", i), i[7:0], {1'b0, i[7:0]});

        // Reload interrupted by reset after four new words
        send_byte(8'hA5);
        send_byte(8'h00);
        for (int i = 0; i < 4; i++) begin
            send_byte(8'h80 + i[7:0]);
            send_byte(8'h01);
        end
        send_byte(8'h77);
        @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        check("t5_rst_state", 32'(dut.state_q),       32'(LD_IDLE));
        check("t5_rst_hold",  32'(bus.o_Cpu_Hold),    32'd1);
        check("t5_rst_ready", 32'(bus.o_Byte_Ready),  32'd1);
        check("t5_rst_instr", 32'(bus.o_Instruction), 32'h0);
        Rst = 1'b1;
        for (int i = 0; i < 4; i++)
            fetch_chk($sformatf("t5_new%0d", i), i[7:0], 9'h180 + 9'(i));
        fetch_chk("t5_old4",   8'd4,   9'h004);
        fetch_chk("t5_old128", 8'd128, 9'h080);
        fetch_chk("t5_old255", 8'd255, 9'h0FF);
        check("t5_idle_hold", 32'(bus.o_Cpu_Hold), 32'd1);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        q = {8'hA5, 8'h01, 8'h3C, 8'h01, 8'h3D};
        send_raw(q);
        repeat (2) @(negedge Clk);
        check("t6_chk_ok_hold", 32'(bus.o_Cpu_Hold), 32'd0);
        check("t6_chk_ok_err",  32'(bus.o_Load_Err), 32'd0);
        fetch_chk("t6_rd0", 8'd0, 9'h13C);
        q = {8'hA5, 8'h01, 8'h3C, 8'h01, 8'h00};
        send_raw(q);
        repeat (2) @(negedge Clk);
        check("t6_chk_bad_err",  32'(bus.o_Load_Err), 32'd1);
        check("t6_chk_bad_hold", 32'(bus.o_Cpu_Hold), 32'd1);
        fetch_chk("t6_rd0_kept", 8'd0, 9'h13C);
`endif

        check("done_with_hold", 32'(done_hold_bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
